// File: rtl/psum_writer.sv
// psum_writer
//   Accumulates the four 8-bit partial-sum lanes of the convolution core
//   across input-channel groups in a per-pixel buffer. On the last pass of
//   each output group it saturates each lane, packs the lanes into one 32-bit
//   word {lane3, lane2, lane1, lane0} and writes it to the output feature-map
//   BRAM at out_base_addr + 4*(grp*WxW_out + pix).
//
// Optional feature: define PSUM_WRITER_RELU_EN to zero negative lane results
//   before clamping (output range [0,127] instead of [-128,127]).
//
// Ports
//   clk, rst             : rising-edge clock, asynchronous active-low reset
//   init_signal          : start pulse, latches the configuration below
//   channel_input_img    : passes (input-channel groups) per output group
//   no_channel_out       : number of output-channel groups
//   WxW_out              : output pixels per channel (1..MAX_PIX)
//   out_base_addr        : byte base address of the output map
//   psum_valid, psum_0..3: one pixel of signed partial sums per valid cycle
//   bram_*               : registered BRAM write port (1-cycle latency)
//   busy, done, cfg_err  : job status; cfg_err is sticky until a valid start
module psum_writer #(
  parameter int MAX_PIX = 1024,
  parameter int ACC_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_signal,
  input  logic [11:0]       channel_input_img,
  input  logic [10:0]       no_channel_out,
  input  logic [15:0]       WxW_out,
  input  logic [31:0]       out_base_addr,
  input  logic              psum_valid,
  input  logic signed [7:0] psum_0,
  input  logic signed [7:0] psum_1,
  input  logic signed [7:0] psum_2,
  input  logic signed [7:0] psum_3,
  output logic [31:0]       bram_addr_out,
  output logic [31:0]       bram_din,
  output logic [3:0]        bram_we,
  output logic              bram_en,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam int PIX_AW = (MAX_PIX > 1) ? $clog2(MAX_PIX) : 1;
  localparam logic [16:0] MAX_PIX_L = 17'(MAX_PIX);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(128);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state_q, state_d;
  logic [11:0] cin_q, cin_d;
  logic [10:0] cout_q, cout_d;
  logic [15:0] wxw_q, wxw_d;
  logic [31:0] base_q, base_d;
  logic [15:0] pix_q, pix_d;
  logic [11:0] pass_q, pass_d;
  logic [10:0] grp_q, grp_d;
  logic [31:0] out_off_q, out_off_d;   // running word index = grp*WxW_out + pix
  logic [31:0] bram_addr_q, bram_addr_d;
  logic [31:0] bram_din_q, bram_din_d;
  logic        bram_wr_q, bram_wr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        cfg_err_q, cfg_err_d;

  logic signed [7:0]       psum_l   [4];
  logic signed [ACC_W-1:0] lane_ext [4];
  logic signed [ACC_W-1:0] lane_prev[4];
  logic signed [ACC_W-1:0] lane_sum [4];
  logic [7:0]              sat_byte [4];

  logic [4*ACC_W-1:0] acc_mem [MAX_PIX];
  logic [4*ACC_W-1:0] acc_rd, mem_wdata;
  logic               mem_we;
  logic [PIX_AW-1:0]  pix_idx;
  logic               cfg_ok, is_final;

  function automatic logic [7:0] sat_lane(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] x;
    x = v;
`ifdef PSUM_WRITER_RELU_EN
    if (x < 0) x = '0;
`endif
    if (x > SAT_MAX) return 8'h7F;
    if (x < SAT_MIN) return 8'h80;
    return x[7:0];
  endfunction

  assign psum_l[0] = psum_0;
  assign psum_l[1] = psum_1;
  assign psum_l[2] = psum_2;
  assign psum_l[3] = psum_3;

  // Asynchronous read: a write at the end of one cycle is visible to the next
  // cycle's read, which covers WxW_out==1 where every valid hits pixel 0.
  assign pix_idx = pix_q[PIX_AW-1:0];
  assign acc_rd  = acc_mem[pix_idx];

  always_ff @(posedge clk) begin
    if (mem_we) acc_mem[pix_idx] <= mem_wdata;
  end

  always_comb begin
    for (int l = 0; l < 4; l++) begin
      lane_ext[l]  = {{(ACC_W-8){psum_l[l][7]}}, psum_l[l]};
      // pass 0 starts a fresh sum; the stale buffer entry is never used
      lane_prev[l] = (pass_q == 12'd0) ? '0 : acc_rd[l*ACC_W +: ACC_W];
      lane_sum[l]  = lane_prev[l] + lane_ext[l];
      sat_byte[l]  = sat_lane(lane_sum[l]);
    end
  end

  always_comb begin
    for (int l = 0; l < 4; l++) mem_wdata[l*ACC_W +: ACC_W] = lane_sum[l];
  end

  assign cfg_ok = (channel_input_img != 12'd0) && (no_channel_out != 11'd0) &&
                  (WxW_out != 16'd0) && ({1'b0, WxW_out} <= MAX_PIX_L);
  assign is_final = (pass_q == cin_q - 12'd1);

  always_comb begin
    state_d     = state_q;
    cin_d       = cin_q;
    cout_d      = cout_q;
    wxw_d       = wxw_q;
    base_d      = base_q;
    pix_d       = pix_q;
    pass_d      = pass_q;
    grp_d       = grp_q;
    out_off_d   = out_off_q;
    bram_addr_d = bram_addr_q;
    bram_din_d  = bram_din_q;
    bram_wr_d   = 1'b0;
    done_d      = 1'b0;
    cfg_err_d   = cfg_err_q;
    mem_we      = 1'b0;

    if (init_signal) begin
      // a start while running aborts the job; counters restart from zero
      pix_d     = '0;
      pass_d    = '0;
      grp_d     = '0;
      out_off_d = '0;
      if (cfg_ok) begin
        cin_d     = channel_input_img;
        cout_d    = no_channel_out;
        wxw_d     = WxW_out;
        base_d    = out_base_addr;
        cfg_err_d = 1'b0;
        state_d   = S_RUN;
      end else begin
        cfg_err_d = 1'b1;
        state_d   = S_IDLE;
      end
    end else if (state_q == S_RUN && psum_valid) begin
      if (is_final) begin
        bram_wr_d   = 1'b1;
        bram_addr_d = base_q + {out_off_q[29:0], 2'b00};
        bram_din_d  = {sat_byte[3], sat_byte[2], sat_byte[1], sat_byte[0]};
        out_off_d   = out_off_q + 32'd1;
      end else begin
        mem_we = 1'b1;
      end

      if (pix_q == wxw_q - 16'd1) begin
        pix_d = '0;
        if (is_final) begin
          pass_d = '0;
          if (grp_q == cout_q - 11'd1) begin
            grp_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            grp_d = grp_q + 11'd1;
          end
        end else begin
          pass_d = pass_q + 12'd1;
        end
      end else begin
        pix_d = pix_q + 16'd1;
      end
    end

    // busy holds through the done cycle and drops on the one after
    busy_d = (state_d == S_RUN) || done_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cin_q       <= '0;
      cout_q      <= '0;
      wxw_q       <= '0;
      base_q      <= '0;
      pix_q       <= '0;
      pass_q      <= '0;
      grp_q       <= '0;
      out_off_q   <= '0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
      bram_wr_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cin_q       <= cin_d;
      cout_q      <= cout_d;
      wxw_q       <= wxw_d;
      base_q      <= base_d;
      pix_q       <= pix_d;
      pass_q      <= pass_d;
      grp_q       <= grp_d;
      out_off_q   <= out_off_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
      bram_wr_q   <= bram_wr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign bram_addr_out = bram_addr_q;
  assign bram_din      = bram_din_q;
  assign bram_we       = {4{bram_wr_q}};
  assign bram_en       = bram_wr_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign cfg_err       = cfg_err_q;

endmodule
